// File: rtl/cdb_wb_arbiter_pkg.sv
// Shared definitions for the CDB writeback path: machine widths, the
// broadcast record seen by ROB/PRF/wakeup, and a saturating counter helper.
package cdb_wb_arbiter_pkg;

   localparam int ROB_W     = 6;
   localparam int PHYS_W    = 7;
   localparam int EPOCH_W   = 3;
   // Widest source index the CDB record can carry (up to 8 sources).
   localparam int MAX_SRC_W = 3;

   typedef struct packed {
      logic                 valid;
      logic [MAX_SRC_W-1:0] src;
      logic [31:0]          pc;
      logic                 uses_rd;
      logic [ROB_W-1:0]     rob_idx;
      logic [PHYS_W-1:0]    prd_new;
      logic [EPOCH_W-1:0]   epoch;
      logic [31:0]          data;
   } cdb_bus_t;

   // 16-bit add that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {13'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/cdb_wb_arbiter_if.sv
// Writeback handshake from the functional units plus the registered CDB
// broadcast. master = FU/consumer side, slave = the arbiter.
interface cdb_wb_arbiter_if
   import cdb_wb_arbiter_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = $clog2(NUM_SRC)
);

   logic [NUM_SRC-1:0]         src_valid;
   logic [NUM_SRC-1:0]         src_ready;
   logic [NUM_SRC*32-1:0]      src_pc;
   logic [NUM_SRC-1:0]         src_uses_rd;
   logic [NUM_SRC*ROB_W-1:0]   src_rob_idx;
   logic [NUM_SRC*PHYS_W-1:0]  src_prd_new;
   logic [NUM_SRC*EPOCH_W-1:0] src_epoch;
   logic [NUM_SRC*32-1:0]      src_data;

   logic                       cdb_valid;
   logic [SRC_W-1:0]           cdb_src;
   logic [31:0]                cdb_pc;
   logic                       cdb_uses_rd;
   logic [ROB_W-1:0]           cdb_rob_idx;
   logic [PHYS_W-1:0]          cdb_prd_new;
   logic [EPOCH_W-1:0]         cdb_epoch;
   logic [31:0]                cdb_data;

   modport master (
      output src_valid, src_pc, src_uses_rd, src_rob_idx, src_prd_new, src_epoch, src_data,
      input  src_ready,
      input  cdb_valid, cdb_src, cdb_pc, cdb_uses_rd, cdb_rob_idx, cdb_prd_new, cdb_epoch, cdb_data
   );

   modport slave (
      input  src_valid, src_pc, src_uses_rd, src_rob_idx, src_prd_new, src_epoch, src_data,
      output src_ready,
      output cdb_valid, cdb_src, cdb_pc, cdb_uses_rd, cdb_rob_idx, cdb_prd_new, cdb_epoch, cdb_data
   );

endinterface

// File: rtl/cdb_wb_arbiter_rr_arbiter.sv
// Generic round-robin picker: the first requester at or after ptr (wrapping)
// wins. Purely combinational so it can also serve RS issue select.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] win,
   output logic         any
);

   // Scan offsets farthest-first so the nearest requester to ptr overwrites last
   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      win   = '0;
      any   = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            win        = W'(idx);
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_wb_arbiter.sv
// CDB writeback arbiter: drains wrong-epoch results silently, grants one live
// source per cycle round-robin, and registers the winner onto the CDB.
module cdb_wb_arbiter
   import cdb_wb_arbiter_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [EPOCH_W-1:0] cur_epoch,
   input  logic               flush,
   cdb_wb_arbiter_if.slave    bus,
   output logic [15:0]        drop_cnt
);

   logic [31:0]        pc_arr    [NUM_SRC];
   logic [31:0]        data_arr  [NUM_SRC];
   logic [ROB_W-1:0]   rob_arr   [NUM_SRC];
   logic [PHYS_W-1:0]  prd_arr   [NUM_SRC];
   logic [EPOCH_W-1:0] epoch_arr [NUM_SRC];

   logic [NUM_SRC-1:0] stale, live, req, grant;
   logic [SRC_W-1:0]   win;
   logic               any_grant;
   logic [3:0]         stale_cnt;

   logic [SRC_W-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [15:0]        drop_cnt_reg;
   logic               cdb_valid_reg;
   logic [SRC_W-1:0]   cdb_src_reg;
   logic [31:0]        cdb_pc_reg, cdb_data_reg;
   logic               cdb_uses_rd_reg;
   logic [ROB_W-1:0]   cdb_rob_idx_reg;
   logic [PHYS_W-1:0]  cdb_prd_new_reg;
   logic [EPOCH_W-1:0] cdb_epoch_reg;

   // Unflatten per-source fields and classify each source against the live epoch
   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         assign pc_arr[gi]    = bus.src_pc[gi*32 +: 32];
         assign data_arr[gi]  = bus.src_data[gi*32 +: 32];
         assign rob_arr[gi]   = bus.src_rob_idx[gi*ROB_W +: ROB_W];
         assign prd_arr[gi]   = bus.src_prd_new[gi*PHYS_W +: PHYS_W];
         assign epoch_arr[gi] = bus.src_epoch[gi*EPOCH_W +: EPOCH_W];
         assign stale[gi]     = bus.src_valid[gi] && (epoch_arr[gi] != cur_epoch);
         assign live[gi]      = bus.src_valid[gi] && !stale[gi];
      end
   endgenerate

   // A flush cycle or reset takes no live result; stale drain is independent.
   assign req = (flush || !rst_n) ? '0 : live;

   rr_arbiter #(.N(NUM_SRC), .W(SRC_W)) u_rr (
      .req   (req),
      .ptr   (rr_ptr_reg),
      .grant (grant),
      .win   (win),
      .any   (any_grant)
   );

   assign bus.src_ready = rst_n ? (stale | grant) : '0;
   assign rr_ptr_next   = (win == SRC_W'(NUM_SRC - 1)) ? '0 : win + 1'b1;

   // Count how many stale results drain this cycle
   always_comb begin
      stale_cnt = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         stale_cnt = stale_cnt + 4'(stale[i]);
      end
   end

   // Register the winning result, advance the pointer past it, accumulate drops
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_reg      <= '0;
         drop_cnt_reg    <= '0;
         cdb_valid_reg   <= 1'b0;
         cdb_src_reg     <= '0;
         cdb_pc_reg      <= '0;
         cdb_uses_rd_reg <= 1'b0;
         cdb_rob_idx_reg <= '0;
         cdb_prd_new_reg <= '0;
         cdb_epoch_reg   <= '0;
         cdb_data_reg    <= '0;
      end else begin
         drop_cnt_reg  <= sat_add16(drop_cnt_reg, stale_cnt);
         cdb_valid_reg <= any_grant;
         if (any_grant) begin
            rr_ptr_reg      <= rr_ptr_next;
            cdb_src_reg     <= win;
            cdb_pc_reg      <= pc_arr[win];
            cdb_uses_rd_reg <= bus.src_uses_rd[win];
            cdb_rob_idx_reg <= rob_arr[win];
            cdb_prd_new_reg <= prd_arr[win];
            cdb_epoch_reg   <= epoch_arr[win];
            cdb_data_reg    <= data_arr[win];
         end
      end
   end

   assign bus.cdb_valid   = cdb_valid_reg;
   assign bus.cdb_src     = cdb_src_reg;
   assign bus.cdb_pc      = cdb_pc_reg;
   assign bus.cdb_uses_rd = cdb_uses_rd_reg;
   assign bus.cdb_rob_idx = cdb_rob_idx_reg;
   assign bus.cdb_prd_new = cdb_prd_new_reg;
   assign bus.cdb_epoch   = cdb_epoch_reg;
   assign bus.cdb_data    = cdb_data_reg;
   assign drop_cnt        = drop_cnt_reg;

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Bench for cdb_wb_arbiter: directed scenarios followed by random traffic,
// all checked against a behavioural model of the writeback rules.
module tb_cdb_wb_arbiter;
   import cdb_wb_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int SW = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               flush = 1'b0;
   logic [EPOCH_W-1:0] cur_epoch = '0;
   logic [15:0]        drop_cnt;

   always #5 clk = ~clk;

   cdb_wb_arbiter_if #(.NUM_SRC(N), .SRC_W(SW)) bus ();

   cdb_wb_arbiter #(.NUM_SRC(N), .SRC_W(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cur_epoch (cur_epoch),
      .flush     (flush),
      .bus       (bus),
      .drop_cnt  (drop_cnt)
   );

   // FU one-entry output buffers
   logic               f_v    [N];
   logic [31:0]        f_pc   [N];
   logic [31:0]        f_data [N];
   logic               f_rd   [N];
   logic [ROB_W-1:0]   f_rob  [N];
   logic [PHYS_W-1:0]  f_prd  [N];
   logic [EPOCH_W-1:0] f_ep   [N];

   // Reference model state
   int       m_ptr;
   int       m_drop;
   cdb_bus_t m_cdb;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic fill(input int i, input logic [EPOCH_W-1:0] ep);
      f_v[i]    = 1'b1;
      f_pc[i]   = $urandom;
      f_data[i] = $urandom;
      f_rd[i]   = 1'($urandom_range(0, 1));
      f_rob[i]  = ROB_W'($urandom);
      f_prd[i]  = PHYS_W'($urandom);
      f_ep[i]   = ep;
   endtask

   // One clock: drive buffers, check ready, advance model, check CDB
   task automatic run_cycle();
      int           win;
      int           nstale;
      logic [N-1:0] exp_rdy;
      for (int i = 0; i < N; i++) begin
         bus.src_valid[i]                   = f_v[i];
         bus.src_uses_rd[i]                 = f_rd[i];
         bus.src_pc[i*32 +: 32]             = f_pc[i];
         bus.src_data[i*32 +: 32]           = f_data[i];
         bus.src_rob_idx[i*ROB_W +: ROB_W]  = f_rob[i];
         bus.src_prd_new[i*PHYS_W +: PHYS_W] = f_prd[i];
         bus.src_epoch[i*EPOCH_W +: EPOCH_W] = f_ep[i];
      end
      #2;
      win = -1;
      if (rst_n && !flush) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (win < 0 && f_v[j] && f_ep[j] == cur_epoch) win = j;
         end
      end
      nstale  = 0;
      exp_rdy = '0;
      for (int i = 0; i < N; i++) begin
         if (rst_n && f_v[i] && f_ep[i] != cur_epoch) begin
            exp_rdy[i] = 1'b1;
            nstale++;
         end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      check_val("src_ready", bus.src_ready, exp_rdy);

      @(posedge clk);
      if (!rst_n) begin
         m_ptr  = 0;
         m_drop = 0;
         m_cdb  = '0;
         for (int i = 0; i < N; i++) f_v[i] = 1'b0;
      end else begin
         m_drop      = (m_drop + nstale > 65535) ? 65535 : m_drop + nstale;
         m_cdb.valid = (win >= 0);
         if (win >= 0) begin
            m_cdb.src     = MAX_SRC_W'(win);
            m_cdb.pc      = f_pc[win];
            m_cdb.uses_rd = f_rd[win];
            m_cdb.rob_idx = f_rob[win];
            m_cdb.prd_new = f_prd[win];
            m_cdb.epoch   = f_ep[win];
            m_cdb.data    = f_data[win];
            m_ptr         = (win + 1) % N;
         end
         for (int i = 0; i < N; i++) if (exp_rdy[i]) f_v[i] = 1'b0;
      end
      #1;
      check_val("cdb_valid", bus.cdb_valid, m_cdb.valid);
      check_val("drop_cnt", drop_cnt, m_drop);
      if (m_cdb.valid || !rst_n) begin
         check_val("cdb_src", bus.cdb_src, m_cdb.src);
         check_val("cdb_pc", bus.cdb_pc, m_cdb.pc);
         check_val("cdb_uses_rd", bus.cdb_uses_rd, m_cdb.uses_rd);
         check_val("cdb_rob_idx", bus.cdb_rob_idx, m_cdb.rob_idx);
         check_val("cdb_prd_new", bus.cdb_prd_new, m_cdb.prd_new);
         check_val("cdb_epoch", bus.cdb_epoch, m_cdb.epoch);
         check_val("cdb_data", bus.cdb_data, m_cdb.data);
      end
      if (bus.cdb_valid)
         $display("t=%0t cdb src=%0d rob=%0d prd=%0d ep=%0d data=%h drop=%0d",
                  $time, bus.cdb_src, bus.cdb_rob_idx, bus.cdb_prd_new, bus.cdb_epoch,
                  bus.cdb_data, drop_cnt);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run_cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         f_v[i] = 1'b0; f_pc[i] = '0; f_data[i] = '0; f_rd[i] = 1'b0;
         f_rob[i] = '0; f_prd[i] = '0; f_ep[i] = '0;
      end
      m_ptr  = 0;
      m_drop = 0;
      m_cdb  = '0;
      @(negedge clk);

      // Reset state
      rst_n = 1'b0;
      run_cycle();
      run_cycle();
      rst_n = 1'b1;

      // Single source
      fill(0, cur_epoch);
      f_data[0] = 32'h0000_00AA;
      f_rob[0]  = ROB_W'(5);
      run_cycle();
      check_val("single_src", bus.cdb_src, 0);
      check_val("single_data", bus.cdb_data, 32'hAA);
      check_val("single_rob", bus.cdb_rob_idx, 5);

      // All four held valid from pointer 0
      do_reset();
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < N; i++) if (!f_v[i]) fill(i, cur_epoch);
         run_cycle();
         check_val("rr_order", bus.cdb_src, c % N);
      end
      for (int i = 0; i < N; i++) f_v[i] = 1'b0;

      // Stale drain alongside a live source
      cur_epoch = 3'd2;
      fill(1, 3'd1);
      fill(2, 3'd2);
      run_cycle();
      check_val("stale_win", bus.cdb_src, 2);
      check_val("stale_drop", drop_cnt, 1);

      // Flush with 0 and 3 live, then resume from same pointer (3)
      fill(0, cur_epoch);
      fill(3, cur_epoch);
      flush = 1'b1;
      run_cycle();
      check_val("flush_quiet", bus.cdb_valid, 0);
      flush = 1'b0;
      run_cycle();
      check_val("flush_resume", bus.cdb_src, 3);
      run_cycle();
      check_val("flush_next", bus.cdb_src, 0);

      // Starvation: ptr=1, src0 always valid, src2 for one cycle
      do_reset();
      fill(0, cur_epoch);
      run_cycle();
      fill(0, cur_epoch);
      fill(2, cur_epoch);
      run_cycle();
      check_val("starve_src2", bus.cdb_src, 2);
      run_cycle();
      check_val("starve_src0", bus.cdb_src, 0);

      // Random traffic with flushes, epoch changes and occasional resets
      for (int c = 0; c < 1000; c++) begin
         flush = ($urandom_range(0, 15) == 0);
         if (flush) cur_epoch = cur_epoch + 1'b1;
         rst_n = ($urandom_range(0, 99) != 0);
         for (int i = 0; i < N; i++)
            if (!f_v[i] && $urandom_range(0, 1) == 1)
               fill(i, ($urandom_range(0, 3) == 0) ? cur_epoch - 1'b1 : cur_epoch);
         run_cycle();
      end
      flush = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) f_v[i] = 1'b0;
      run_cycle();

      // Reset while a broadcast is registered
      fill(1, cur_epoch);
      run_cycle();
      check_val("pre_reset_valid", bus.cdb_valid, 1);
      fill(2, cur_epoch);
      rst_n = 1'b0;
      run_cycle();
      check_val("reset_valid", bus.cdb_valid, 0);
      check_val("reset_drop", drop_cnt, 0);
      rst_n = 1'b1;
      fill(3, cur_epoch);
      fill(0, cur_epoch);
      run_cycle();
      check_val("reset_ptr", bus.cdb_src, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
